// File: rtl/lane_pkg.sv
// lane_pkg: constants shared by the lane serializer and its inverse deserializer.
//   LANE_WIDTH       word width in bits
//   LANE_DEPTH       default FIFO depth
//   LANE_SYNC_WORDS  default number of COM words sent after reset
//   LANE_COM_WORD    sync pattern
//   LANE_IDLE_WORD   filler pattern
//   ST_SYNC/ST_RUN   framing state encoding
package lane_pkg;

  localparam int unsigned LANE_WIDTH      = 32;
  localparam int unsigned LANE_DEPTH      = 2;
  localparam int unsigned LANE_SYNC_WORDS = 4;

  localparam logic [LANE_WIDTH-1:0] LANE_COM_WORD  = 32'hBCBC_BCBC;
  localparam logic [LANE_WIDTH-1:0] LANE_IDLE_WORD = 32'h7C7C_7C7C;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: synchronous DEPTH x WIDTH FIFO with a combinational head.
//   clk    clock, all logic on posedge
//   reset  synchronous, active-high; empties the FIFO
//   push   write din at the tail (ignored when full)
//   pop    advance the head (ignored when empty)
//   din    write data
//   dout   current head word (combinational)
//   count  number of stored words
//   full   count == DEPTH
//   empty  count == 0
module lane_fifo
  import lane_pkg::*;
#(
  parameter int unsigned WIDTH = LANE_WIDTH,
  parameter int unsigned DEPTH = LANE_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_serializer.sv
// lane_serializer: buffers lane words and shifts them out MSB-first, one bit
// per clock, framing the line with COM words after reset and IDLE words when
// no data is queued.
//   clk_32f     bit clock, all logic on posedge
//   reset       synchronous, active-high
//   data_in     lane word from striping
//   valid_in    data_in is valid this cycle
//   ready_out   FIFO can accept a word this cycle
//   serial_out  serial bit stream, MSB first
//   word_start  high while serial_out carries the MSB of a word
//   is_data     current word is a data word
//   overflow    sticky, set when a word is dropped
module lane_serializer
  import lane_pkg::*;
#(
  parameter int unsigned      WIDTH      = LANE_WIDTH,
  parameter int unsigned      DEPTH      = LANE_DEPTH,
  parameter int unsigned      SYNC_WORDS = LANE_SYNC_WORDS,
  parameter logic [WIDTH-1:0] COM_WORD   = LANE_COM_WORD,
  parameter logic [WIDTH-1:0] IDLE_WORD  = LANE_IDLE_WORD
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             serial_out,
  output logic             word_start,
  output logic             is_data,
  output logic             overflow
);

  localparam int unsigned BIT_W  = $clog2(WIDTH);
  localparam int unsigned SYNC_W = (SYNC_WORDS > 0) ? $clog2(SYNC_WORDS + 1) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  localparam logic [SYNC_W-1:0] SYNC_LAST  = SYNC_W'(SYNC_WORDS);
  localparam logic [CNT_W-1:0]  FIFO_DEPTH = CNT_W'(DEPTH);
  localparam logic [BIT_W-1:0]  BIT_MSB    = BIT_W'(WIDTH - 1);

  logic [0:0]        state_q,    state_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [BIT_W-1:0]  bit_idx_q,  bit_idx_d;
  logic [WIDTH-1:0]  shreg_q,    shreg_d;
  logic              started_q,  started_d;
  logic              is_data_d;
  logic              word_start_d;
  logic              overflow_d;

  logic              boundary;
  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  assign ready_out  = !reset && (fifo_count < FIFO_DEPTH);
  assign push       = valid_in && ready_out;
  // The shift register MSB is the bit on the line this cycle.
  assign serial_out = shreg_q[WIDTH-1];

  lane_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_32f),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state: word selection at boundaries, shifting otherwise.
  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = sync_cnt_q;
    bit_idx_d    = bit_idx_q - BIT_W'(1);
    shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
    started_d    = 1'b1;
    is_data_d    = is_data;
    word_start_d = 1'b0;
    overflow_d   = overflow || (valid_in && fifo_full);
    pop          = 1'b0;

    // First edge out of reset, or the edge after bit 0 was on the line.
    boundary = !started_q || (bit_idx_q == '0);

    if (boundary) begin
      bit_idx_d    = BIT_MSB;
      word_start_d = 1'b1;
      if ((state_q == ST_SYNC) && (sync_cnt_q < SYNC_LAST)) begin
        shreg_d    = COM_WORD;
        is_data_d  = 1'b0;
        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        if (sync_cnt_d == SYNC_LAST) begin
          state_d = ST_RUN;
        end
      end else if ((state_q == ST_RUN) && !fifo_empty) begin
        pop       = 1'b1;
        shreg_d   = fifo_dout;
        is_data_d = 1'b1;
      end else begin
        shreg_d   = IDLE_WORD;
        is_data_d = 1'b0;
        state_d   = ST_RUN;
      end
    end
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= ST_SYNC;
      sync_cnt_q <= '0;
      bit_idx_q  <= BIT_MSB;
      shreg_q    <= '0;
      started_q  <= 1'b0;
      is_data    <= 1'b0;
      word_start <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      started_q  <= started_d;
      is_data    <= is_data_d;
      word_start <= word_start_d;
      overflow   <= overflow_d;
    end
  end

endmodule
